// File: rtl/ins_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package ins_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_HI  = 3'd1,
    ST_HDR_LO  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } ldr_state_t;

  // Header is a big-endian word count; payload words are big-endian 32-bit
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_W        = 8 * HDR_BYTES;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  // States in which the loader is willing to take a byte
  function automatic logic is_rx_state(input ldr_state_t s);
    return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_PAYLOAD);
  endfunction

  // States in which Start is honoured
  function automatic logic is_idle_state(input ldr_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/ins_loader_ldr_timeout.sv
// Idle-cycle watchdog: counts enabled cycles, clears on demand, and flags
// the cycle in which the TIMEOUT-th consecutive idle cycle occurs.
module ins_loader_ldr_timeout #(
  parameter int TIMEOUT = 100000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic Expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_reg;

  // Terminal flag fires during the idle cycle that completes the budget
  assign Expired = en && !clr && (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Idle counter: clear wins, stops once the terminal count is reached
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !Expired) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ins_loader.sv
// Program loader: parses a word-count header from a byte stream, assembles
// big-endian instruction words, writes them to instruction memory and holds
// the core in reset until the whole image has been written.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int TIMEOUT   = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [7:0]  RxData,
  input  logic        RxValid,
  output logic        RxReady,
  output logic [31:0] W_Ins,
  output logic        WE,
  output logic [31:0] WAddr,
  output logic        CpuHold,
  output logic        Done,
  output logic        Err
);

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  ldr_state_t              state_reg, state_next;
  logic [COUNT_W-1:0]      count_reg;
  logic [BYTE_IDX_W-1:0]   byte_idx_reg;
  logic [23:0]             asm_reg;
  logic [31:0]             w_ins_reg;
  logic [31:0]             waddr_reg;
  logic                    we_reg;
  logic                    rx_ready_reg;
  logic                    cpu_hold_reg;
  logic                    done_reg;
  logic                    err_reg;

  logic                    xfer;
  logic                    start_ok;
  logic                    tmo_en;
  logic                    tmo_clr;
  logic                    tmo_expired;
  logic [COUNT_W-1:0]      hdr_count;
  logic                    last_word;

  // RxReady is registered from the state, so it already gates the handshake
  assign xfer      = RxValid && rx_ready_reg;
  assign start_ok  = Start && is_idle_state(state_reg);
  assign tmo_en    = ((state_reg == ST_HDR_LO) || (state_reg == ST_PAYLOAD)) && !xfer;
  assign tmo_clr   = xfer || start_ok;
  assign hdr_count = {count_reg[COUNT_W-1:8], RxData};
  assign last_word = ((waddr_reg + 32'd1) == 32'(count_reg));

  ins_loader_ldr_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .Expired (tmo_expired)
  );

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (Start) state_next = ST_HDR_HI;
      end
      ST_HDR_HI: begin
        if (xfer) state_next = ST_HDR_LO;
      end
      ST_HDR_LO: begin
        if (tmo_expired) begin
          state_next = ST_ERR;
        end else if (xfer) begin
          if (hdr_count == '0)
            state_next = ST_DONE;
          else if (32'(hdr_count) > 32'(MAX_WORDS))
            state_next = ST_ERR;
          else
            state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (tmo_expired)
          state_next = ST_ERR;
        else if (xfer && (byte_idx_reg == LAST_IDX))
          state_next = ST_WRITE;
      end
      ST_WRITE: begin
        state_next = last_word ? ST_DONE : ST_PAYLOAD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and registered status outputs decoded from the next state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= ST_IDLE;
      rx_ready_reg <= 1'b0;
      we_reg       <= 1'b0;
      cpu_hold_reg <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rx_ready_reg <= is_rx_state(state_next);
      we_reg       <= (state_next == ST_WRITE);
      cpu_hold_reg <= (state_next != ST_DONE);
      done_reg     <= (state_next == ST_DONE);
      err_reg      <= (state_next == ST_ERR);
    end
  end

  // Header capture, word assembly and write-address tracking
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_reg    <= '0;
      byte_idx_reg <= '0;
      asm_reg      <= '0;
      w_ins_reg    <= '0;
      waddr_reg    <= '0;
    end else begin
      if (start_ok) begin
        waddr_reg    <= '0;
        byte_idx_reg <= '0;
      end
      case (state_reg)
        ST_HDR_HI: if (xfer) count_reg[COUNT_W-1:8] <= RxData;
        ST_HDR_LO: if (xfer) count_reg[7:0] <= RxData;
        ST_PAYLOAD: begin
          if (xfer) begin
            case (byte_idx_reg)
              2'd0:    asm_reg[23:16] <= RxData;
              2'd1:    asm_reg[15:8]  <= RxData;
              2'd2:    asm_reg[7:0]   <= RxData;
              default: w_ins_reg      <= {asm_reg, RxData};
            endcase
            byte_idx_reg <= byte_idx_reg + 1'b1;
          end
        end
        ST_WRITE: begin
          waddr_reg    <= waddr_reg + 32'd1;
          byte_idx_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign RxReady = rx_ready_reg;
  assign W_Ins   = w_ins_reg;
  assign WE      = we_reg;
  assign WAddr   = waddr_reg;
  assign CpuHold = cpu_hold_reg;
  assign Done    = done_reg;
  assign Err     = err_reg;

endmodule

// File: tb/tb_ins_loader.sv
// Directed self-checking bench for ins_loader (TIMEOUT shortened to 50).
module tb_ins_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] w_ins;
  logic        we;
  logic [31:0] waddr;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int checks = 0;
  int passes = 0;

  // Write log filled by the monitor
  int          wr_cnt = 0;
  int          we_double = 0;
  logic        prev_we = 1'b0;
  logic [31:0] wr_data [0:31];
  logic [31:0] wr_addr [0:31];
  int          base;

  always #5 clk = ~clk;

  ins_loader #(
    .MAX_WORDS (1024),
    .TIMEOUT   (50)
  ) dut (
    .CLK     (clk),
    .RST     (rst_n),
    .Start   (start),
    .RxData  (rx_data),
    .RxValid (rx_valid),
    .RxReady (rx_ready),
    .W_Ins   (w_ins),
    .WE      (we),
    .WAddr   (waddr),
    .CpuHold (cpu_hold),
    .Done    (done),
    .Err     (err)
  );

  // Record every write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (we) begin
      if (wr_cnt < 32) begin
        wr_data[wr_cnt] = w_ins;
        wr_addr[wr_cnt] = waddr;
      end
      $display("write addr=%0d data=%08h", waddr, w_ins);
      if (prev_we) we_double = we_double + 1;
      wr_cnt = wr_cnt + 1;
    end
    prev_we = we;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Offer one byte from a negedge and return at the negedge after it is taken
  task automatic send(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("send_ready_timeout", 32'(rx_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send(w[31 - 8*i -: 8]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_w_ins"},    w_ins,            32'h0);
    chk({tag, "_we"},       32'(we),          32'd0);
    chk({tag, "_waddr"},    waddr,            32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready),    32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold),    32'd1);
    chk({tag, "_done"},     32'(done),        32'd0);
    chk({tag, "_err"},      32'(err),         32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", 32'(rx_ready), 32'd0);

    // Basic two-word load
    base = wr_cnt;
    pulse_start();
    chk("basic_armed_rx_ready", 32'(rx_ready), 32'd1);
    chk("basic_armed_hold", 32'(cpu_hold), 32'd1);
    send(8'h00); send(8'h02);
    send_word(32'h20080005, 0);
    send_word(32'h01095020, 0);
    chk("basic_we2", 32'(we), 32'd1);
    chk("basic_we2_addr", waddr, 32'd1);
    chk("basic_we2_data", w_ins, 32'h01095020);
    chk("basic_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_hold_release", 32'(cpu_hold), 32'd0);
    chk("basic_we_low", 32'(we), 32'd0);
    chk("basic_done_rx_ready", 32'(rx_ready), 32'd0);
    chk("basic_w_ins_hold", w_ins, 32'h01095020);
    chk("basic_nwrites", 32'(wr_cnt - base), 32'd2);
    chk("basic_w0_data", wr_data[base], 32'h20080005);
    chk("basic_w0_addr", wr_addr[base], 32'd0);
    chk("basic_w1_data", wr_data[base+1], 32'h01095020);
    chk("basic_w1_addr", wr_addr[base+1], 32'd1);

    // Start from DONE re-arms; zero-count header
    base = wr_cnt;
    pulse_start();
    chk("rearm_hold", 32'(cpu_hold), 32'd1);
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_rx_ready", 32'(rx_ready), 32'd1);
    chk("rearm_waddr", waddr, 32'd0);
    send(8'h00); send(8'h00);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_hold", 32'(cpu_hold), 32'd0);
    chk("zero_nwrites", 32'(wr_cnt - base), 32'd0);

    // Oversize header 0x0401
    base = wr_cnt;
    pulse_start();
    send(8'h04); send(8'h01);
    chk("over_err", 32'(err), 32'd1);
    chk("over_rx_ready", 32'(rx_ready), 32'd0);
    chk("over_hold", 32'(cpu_hold), 32'd1);
    repeat (5) @(negedge clk);
    chk("over_err_sticky", 32'(err), 32'd1);
    pulse_start();
    chk("over_restart_err", 32'(err), 32'd0);
    chk("over_restart_rx_ready", 32'(rx_ready), 32'd1);
    send(8'h00); send(8'h01);
    send_word(32'hDEADBEEF, 0);
    @(negedge clk);
    chk("over_reload_done", 32'(done), 32'd1);
    chk("over_nwrites", 32'(wr_cnt - base), 32'd1);
    chk("over_w0_data", wr_data[base], 32'hDEADBEEF);
    chk("over_w0_addr", wr_addr[base], 32'd0);

    // Random RxValid gaps over a three-word image
    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h03);
    send_word(32'h12345678, 4);
    send_word(32'h9ABCDEF0, 4);
    send_word(32'h0F1E2D3C, 4);
    @(negedge clk);
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_nwrites", 32'(wr_cnt - base), 32'd3);
    chk("gap_w0_data", wr_data[base], 32'h12345678);
    chk("gap_w1_data", wr_data[base+1], 32'h9ABCDEF0);
    chk("gap_w2_data", wr_data[base+2], 32'h0F1E2D3C);
    chk("gap_w2_addr", wr_addr[base+2], 32'd2);
    chk("gap_final_waddr", waddr, 32'd3);

    // Timeout after 6 payload bytes
    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h03);
    send_word(32'hAABBCCDD, 0);
    send(8'h11); send(8'h22);
    repeat (49) @(negedge clk);
    chk("tmo_err_at_49", 32'(err), 32'd0);
    chk("tmo_rx_ready_at_49", 32'(rx_ready), 32'd1);
    @(negedge clk);
    chk("tmo_err_at_50", 32'(err), 32'd1);
    chk("tmo_rx_ready_at_50", 32'(rx_ready), 32'd0);
    chk("tmo_nwrites", 32'(wr_cnt - base), 32'd1);
    chk("tmo_w0_data", wr_data[base], 32'hAABBCCDD);
    chk("tmo_w0_addr", wr_addr[base], 32'd0);
    chk("tmo_w_ins_hold", w_ins, 32'hAABBCCDD);

    // Reset in the middle of word 1
    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h02);
    send_word(32'hCAFEF00D, 0);
    send(8'h01); send(8'h02); send(8'h03);
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_nwrites", 32'(wr_cnt - base), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h01);
    send_word(32'h13572468, 0);
    chk("fresh_we", 32'(we), 32'd1);
    chk("fresh_waddr", waddr, 32'd0);
    chk("fresh_data", w_ins, 32'h13572468);
    @(negedge clk);
    chk("fresh_done", 32'(done), 32'd1);

    // Start while in PAYLOAD is ignored
    base = wr_cnt;
    pulse_start();
    send(8'h00); send(8'h01);
    send(8'hA1); send(8'hB2);
    pulse_start();
    chk("busy_rx_ready", 32'(rx_ready), 32'd1);
    send(8'hC3); send(8'hD4);
    chk("busy_we", 32'(we), 32'd1);
    chk("busy_data", w_ins, 32'hA1B2C3D4);
    chk("busy_waddr", waddr, 32'd0);
    @(negedge clk);
    chk("busy_done", 32'(done), 32'd1);
    chk("busy_nwrites", 32'(wr_cnt - base), 32'd1);

    chk("we_never_back_to_back", 32'(we_double), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
